// File: rtl/pc_gen_btb_pkg.sv
// Shared encodings for the fetch PC generator: pc_src values, 2-bit branch
// counter states, stall_state bit positions and the counter update rule.
package pc_gen_btb_pkg;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BTB = 2'b01,
      PCSRC_JMP = 2'b10,
      PCSRC_EX  = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam int STALL_FETCH = 0;
   localparam int STALL_HARD  = 1;

   // Saturating step towards the resolved direction.
   function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
      ctr_e nxt;
      nxt = ctr;
      if (taken && ctr != ST)
         nxt = ctr_e'(ctr + 2'd1);
      else if (!taken && ctr != SNT)
         nxt = ctr_e'(ctr - 2'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/pc_gen_btb_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// clocked training port from EX resolution, synchronous whole-table flush.
module btb_dm
   import pc_gen_btb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem    [ENTRIES];
   logic [ADDR_W-1:0]  target_mem [ENTRIES];
   ctr_e               ctr_mem    [ENTRIES];

   logic [IDX_W-1:0] lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic             lk_hit, upd_hit;
   logic             unused_lsb;

   assign lk_idx  = lk_pc[IDX_W+1:2];
   assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

   // Instruction-aligned PCs: the byte-offset bits carry no information.
   assign unused_lsb = ^{lk_pc[1:0], upd_pc[1:0]};

   assign lk_hit      = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
   assign pred_taken  = lk_hit && ctr_mem[lk_idx][1];
   assign pred_target = pred_taken ? target_mem[lk_idx] : '0;

   assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

   // NOTE: sequential state uses <= so every reader sees pre-edge values,
   // which is what gives lookup-before-update ordering within one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         valid <= '0;
      else if (flush)
         valid <= '0;
      else if (upd_en && !upd_hit && upd_taken)
         valid[upd_idx] <= 1'b1;
   end

   // NOTE: the payload arrays have no reset; the valid bits alone decide
   // whether an entry is visible, so stale payload is harmless.
   always_ff @(posedge clk) begin
      if (!flush && upd_en) begin
         if (upd_hit) begin
            ctr_mem[upd_idx] <= ctr_update(ctr_mem[upd_idx], upd_taken);
            if (upd_taken)
               target_mem[upd_idx] <= upd_target;
         end else if (upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
            ctr_mem[upd_idx]    <= WT;
         end
      end
   end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch PC generator: registered PC with stall/redirect priority, a BTB-based
// taken-branch prediction and sequential increment as the fallback.
module pc_gen_btb
   import pc_gen_btb_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                BTB_ENTRIES = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                INST_BYTES  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        stall_state,
   input  logic              ex_be_i,
   input  logic [ADDR_W-1:0] ex_bto_i,
   input  logic              id_je_i,
   input  logic [ADDR_W-1:0] id_jto_i,
   input  logic              upd_en_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              btb_flush_i,
   output logic [ADDR_W-1:0] pc,
   output logic [1:0]        pc_src,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] pred_target_o
);

   pc_src_e           src_q, src_d;
   logic [ADDR_W-1:0] pc_d;

   btb_dm #(
      .ADDR_W  (ADDR_W),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .flush       (btb_flush_i),
      .lk_pc       (pc),
      .pred_taken  (pred_taken_o),
      .pred_target (pred_target_o),
      .upd_en      (upd_en_i),
      .upd_pc      (upd_pc_i),
      .upd_taken   (upd_taken_i),
      .upd_target  (upd_target_i)
   );

   // NOTE: defaults first, so every path assigns pc_d/src_d and no latch forms.
   always_comb begin
      pc_d  = pc;
      src_d = src_q;
      // A hard stall freezes the PC even against an EX redirect.
      if (!stall_state[STALL_HARD]) begin
         if (ex_be_i) begin
            pc_d  = ex_bto_i;
            src_d = PCSRC_EX;
         end else if (!stall_state[STALL_FETCH]) begin
            if (id_je_i) begin
               pc_d  = id_jto_i;
               src_d = PCSRC_JMP;
            end else if (pred_taken_o) begin
               pc_d  = pred_target_o;
               src_d = PCSRC_BTB;
            end else begin
               pc_d  = pc + ADDR_W'(INST_BYTES);
               src_d = PCSRC_SEQ;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc    <= RESET_PC;
         src_q <= PCSRC_SEQ;
      end else begin
         pc    <= pc_d;
         src_q <= src_d;
      end
   end

   assign pc_src = src_q;

endmodule
